// File: rtl/prog_loader.sv
// ============================================================================
//  Module      : prog_loader
//  Description : Boot loader for the 16-bit single-cycle CPU. Receives a
//                framed byte stream (HEADER, LEN, LEN x {hi,lo}, CSUM),
//                assembles 16-bit words and writes them into instruction
//                memory. Holds the CPU in reset until a complete,
//                checksum-valid program has been loaded.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                i_rx_valid/data - incoming byte stream
//                o_rx_ready      - byte accepted on valid && ready
//                o_prog_we/addr/data - instruction memory write port
//                o_cpu_reset     - 1 = CPU held in reset
//                o_done/o_error  - status of the last frame
//  Options     : LOADER_TIMEOUT_EN - abort a frame after TIMEOUT idle cycles
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_loader #(
    parameter int          DEPTH   = 64,
    parameter int          ADDR_W  = 6,
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int          TIMEOUT = 1024
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_rx_valid,
    input  wire logic [7:0]        i_rx_data,
    output logic                   o_rx_ready,
    output logic                   o_prog_we,
    output logic [ADDR_W-1:0]      o_prog_addr,
    output logic [15:0]            o_prog_data,
    output logic                   o_cpu_reset,
    output logic                   o_done,
    output logic                   o_error
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LEN  = 3'd1,
        S_HI   = 3'd2,
        S_LO   = 3'd3,
        S_CSUM = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    localparam logic [8:0] c_DEPTH9 = 9'(DEPTH);

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_rx_ready;
    logic                r_prog_we;
    logic [ADDR_W-1:0]   r_prog_addr;
    logic [15:0]         r_prog_data;
    logic                r_cpu_reset;
    logic                r_done;
    logic                r_error;
    logic [7:0]          r_acc;
    logic [7:0]          r_hi;
    logic [ADDR_W:0]     r_len;     // one bit wider than the address: holds up to DEPTH
    logic [ADDR_W:0]     r_idx;

    logic                w_accept;
    logic                w_hdr;
    logic                w_len_ok;
    logic                w_last;
    logic                w_mid_frame;
    logic                w_timeout;

    assign w_accept    = i_rx_valid & r_rx_ready;
    assign w_len_ok    = (i_rx_data != 8'd0) && ({1'b0, i_rx_data} <= c_DEPTH9);
    assign w_last      = ((r_idx + 1'b1) == r_len);
    assign w_mid_frame = (r_state == S_LEN) || (r_state == S_HI) ||
                         (r_state == S_LO)  || (r_state == S_CSUM);
    // A header only starts a frame between frames; mid-frame it is plain data.
    assign w_hdr       = w_accept && (i_rx_data == HEADER) &&
                         ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

`ifdef LOADER_TIMEOUT_EN
    localparam int c_TMO_W = $clog2(TIMEOUT + 1);

    logic [c_TMO_W-1:0] r_tmo_cnt;

    // Counter holds the number of consecutive byte-less cycles spent mid-frame;
    // the edge that would make it TIMEOUT aborts the frame instead.
    always_ff @(posedge clk) begin
        if (reset || !w_mid_frame || w_accept) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
        end
    end

    assign w_timeout = w_mid_frame && !w_accept &&
                       (r_tmo_cnt == c_TMO_W'(TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_hdr) begin
                    w_state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    w_state_nxt = w_len_ok ? S_HI : S_ERR;
                end
            end
            S_HI: begin
                if (w_accept) begin
                    w_state_nxt = S_LO;
                end
            end
            S_LO: begin
                if (w_accept) begin
                    w_state_nxt = w_last ? S_CSUM : S_HI;
                end
            end
            S_CSUM: begin
                if (w_accept) begin
                    w_state_nxt = (i_rx_data == r_acc) ? S_DONE : S_ERR;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_timeout) begin
            w_state_nxt = S_ERR;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_ready  <= 1'b0;
            r_prog_we   <= 1'b0;
            r_prog_addr <= '0;
            r_prog_data <= '0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_acc       <= '0;
            r_hi        <= '0;
            r_len       <= '0;
            r_idx       <= '0;
        end else begin
            r_rx_ready <= 1'b1;
            r_prog_we  <= 1'b0;
            // CPU runs only while resting in DONE; a reload header holds it again.
            r_cpu_reset <= !((r_state == S_DONE) && !w_hdr);

            if (w_hdr) begin
                r_done  <= 1'b0;
                r_error <= 1'b0;
                r_acc   <= '0;
                r_idx   <= '0;
            end else if ((r_state != S_ERR) && (w_state_nxt == S_ERR)) begin
                r_error <= 1'b1;
            end else if ((r_state == S_CSUM) && (w_state_nxt == S_DONE)) begin
                r_done <= 1'b1;
            end

            if (w_accept && !w_timeout) begin
                case (r_state)
                    S_LEN: begin
                        if (w_len_ok) begin
                            r_len <= i_rx_data[ADDR_W:0];
                            r_acc <= i_rx_data;
                        end
                    end
                    S_HI: begin
                        r_hi  <= i_rx_data;
                        r_acc <= r_acc ^ i_rx_data;
                    end
                    S_LO: begin
                        r_acc       <= r_acc ^ i_rx_data;
                        r_prog_we   <= 1'b1;
                        r_prog_addr <= r_idx[ADDR_W-1:0];
                        r_prog_data <= {r_hi, i_rx_data};
                        r_idx       <= r_idx + 1'b1;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign o_rx_ready  = r_rx_ready;
    assign o_prog_we   = r_prog_we;
    assign o_prog_addr = r_prog_addr;
    assign o_prog_data = r_prog_data;
    assign o_cpu_reset = r_cpu_reset;
    assign o_done      = r_done;
    assign o_error     = r_error;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ============================================================================
//  Module      : tb_prog_loader
//  Description : Self-checking bench for prog_loader. Frames are built at the
//                frame level (length, word list, checksum rule) and the
//                expected writes and status flags are derived from them.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_loader;

    localparam int         DEPTH   = 64;
    localparam int         ADDR_W  = 6;
    localparam logic [7:0] HEADER  = 8'hA5;
    localparam int         TIMEOUT = 1024;

    logic              clk = 1'b0;
    logic              reset;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              rx_ready;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;
    logic              cpu_reset;
    logic              done;
    logic              error;

    int n_vec = 0;
    int n_err = 0;
    int wr_count = 0;
    logic [15:0] q_words[$];

    prog_loader #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .HEADER  (HEADER),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_valid  (rx_valid),
        .i_rx_data   (rx_data),
        .o_rx_ready  (rx_ready),
        .o_prog_we   (prog_we),
        .o_prog_addr (prog_addr),
        .o_prog_data (prog_data),
        .o_cpu_reset (cpu_reset),
        .o_done      (done),
        .o_error     (error)
    );

    always #5 clk = ~clk;

    // Each write pulse lasts one cycle, so one sample per cycle counts it once.
    always @(negedge clk) begin
        if (prog_we === 1'b1) wr_count <= wr_count + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int gap;
        gap = $urandom_range(0, 2);
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 32'(rx_ready),  32'd0);
        chk({tag, "_we"},    32'(prog_we),   32'd0);
        chk({tag, "_addr"},  32'(prog_addr), 32'd0);
        chk({tag, "_data"},  32'(prog_data), 32'd0);
        chk({tag, "_cpurst"},32'(cpu_reset), 32'd1);
        chk({tag, "_done"},  32'(done),      32'd0);
        chk({tag, "_error"}, 32'(error),     32'd0);
    endtask

    // Non-header bytes between frames must change nothing.
    task automatic send_garbage(input int n);
        logic [7:0] b;
        logic d0, e0, c0;
        int w0;
        d0 = done; e0 = error; c0 = cpu_reset; w0 = wr_count;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            if (b == HEADER) b = 8'h00;
            send_byte(b);
        end
        chk("garbage_done",   32'(done),      32'(d0));
        chk("garbage_error",  32'(error),     32'(e0));
        chk("garbage_cpurst", 32'(cpu_reset), 32'(c0));
        chk("garbage_writes", 32'(wr_count - w0), 32'd0);
    endtask

    // Send one frame. Words come from q_words; csum_mask != 0 corrupts the checksum.
    task automatic run_frame(input int len, input logic [7:0] csum_mask);
        logic [7:0] cs;
        logic       good;
        int         w0;
        w0 = wr_count;
        send_byte(HEADER);
        chk("hdr_done",   32'(done),      32'd0);
        chk("hdr_error",  32'(error),     32'd0);
        chk("hdr_cpurst", 32'(cpu_reset), 32'd1);
        send_byte(8'(len));
        if (len < 1 || len > DEPTH) begin
            chk("badlen_error",  32'(error),     32'd1);
            chk("badlen_done",   32'(done),      32'd0);
            @(posedge clk); #1;
            chk("badlen_cpurst", 32'(cpu_reset), 32'd1);
            chk("badlen_writes", 32'(wr_count - w0), 32'd0);
            return;
        end
        cs = 8'(len);
        for (int i = 0; i < len; i++) begin
            send_byte(q_words[i][15:8]);
            send_byte(q_words[i][7:0]);
            chk("wr_we",   32'(prog_we),   32'd1);
            chk("wr_addr", 32'(prog_addr), 32'(i));
            chk("wr_data", 32'(prog_data), 32'(q_words[i]));
            cs = cs ^ q_words[i][15:8] ^ q_words[i][7:0];
        end
        good = (csum_mask == 8'h00);
        send_byte(cs ^ csum_mask);
        chk("csum_done",   32'(done),      32'(good));
        chk("csum_error",  32'(error),     32'(!good));
        chk("csum_cpurst", 32'(cpu_reset), 32'd1);
        @(posedge clk); #1;
        chk("post_cpurst", 32'(cpu_reset), 32'(!good));
        chk("frame_writes", 32'(wr_count - w0), 32'(len));
    endtask

    task automatic fill_words(input int len);
        q_words.delete();
        for (int i = 0; i < len; i++) q_words.push_back(16'($urandom));
    endtask

    initial begin
        int len;
        logic [7:0] mask;
        logic [7:0] cs;

        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_first_cycle", 32'(rx_ready), 32'd0);
        @(posedge clk); #1;
        chk("ready_after", 32'(rx_ready), 32'd1);

        // Directed frames from the test plan
        send_garbage(3);
        q_words = '{16'h1234, 16'hABCD};
        run_frame(2, 8'h00);
        send_garbage(2);
        chk("done_cpu_running", 32'(cpu_reset), 32'd0);
        run_frame(2, 8'h01);           // checksum 43 instead of 42
        run_frame(0, 8'h00);
        run_frame(65, 8'h00);
        send_garbage(2);
        q_words = '{16'h1234, 16'hABCD};
        run_frame(2, 8'h00);
        q_words = '{16'hBEEF};          // reload from DONE
        run_frame(1, 8'h00);

        // Inter-byte idle mid-frame
        send_byte(HEADER);
        send_byte(8'h02);
        send_byte(8'h12);
`ifdef LOADER_TIMEOUT_EN
        repeat (TIMEOUT - 2) @(posedge clk);
        #1;
        chk("tmo_early_error", 32'(error), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        chk("tmo_error",  32'(error),     32'd1);
        chk("tmo_cpurst", 32'(cpu_reset), 32'd1);
        chk("tmo_done",   32'(done),      32'd0);
`else
        repeat (TIMEOUT + 10) @(posedge clk);
        #1;
        chk("notmo_error",  32'(error),     32'd0);
        chk("notmo_cpurst", 32'(cpu_reset), 32'd1);
        send_byte(8'h34);
        chk("notmo_wr0", 32'(prog_data), 32'h1234);
        send_byte(8'h56);
        send_byte(8'h78);
        chk("notmo_wr1_addr", 32'(prog_addr), 32'd1);
        chk("notmo_wr1_data", 32'(prog_data), 32'h5678);
        cs = 8'h02 ^ 8'h12 ^ 8'h34 ^ 8'h56 ^ 8'h78;
        send_byte(cs);
        chk("notmo_done", 32'(done), 32'd1);
`endif

        // Reset in the middle of a frame
        send_byte(HEADER);
        send_byte(8'h02);
        send_byte(8'h12);
        send_byte(8'h34);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        q_words = '{16'hCAFE, 16'h0F0F, 16'h5AA5};
        run_frame(3, 8'h00);

        // Randomised frames
        for (int f = 0; f < 40; f++) begin
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = $urandom_range(DEPTH + 1, 255);
                2:       len = DEPTH;
                default: len = $urandom_range(1, 8);
            endcase
            mask = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            if (len >= 1 && len <= DEPTH) fill_words(len);
            run_frame(len, mask);
            if ($urandom_range(0, 2) == 0) send_garbage($urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
